cyborg65r2_i2c_master: RTL and testbench
========================================

// Module: cyborg65r2_i2c_master
// PURPOSE
//  I2C controller (bus master) for the 32-entry register map of the CYBORG65R2 I2C slave.
//  - Converts single-register write/read commands into I2C transactions.
//  - Sits in the bring-up/test companion logic and drives scl/sda of the chip under test.
//  - Supports config registers 0-23 (read-write) and status registers 24-31 (read-only).
// PARAMETERS
//  CLK_DIV   25     clk cycles per quarter SCL period (SCL period = 4*CLK_DIV), >=2
//  DEV_ADDR  7'h52  7-bit slave device address
// PORTS
//  clk           in   1  single clock; all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  cmd_valid     in   1  command request
//  cmd_ready     out  1  command accepted when cmd_valid & cmd_ready
//  cmd_rw        in   1  0 = write, 1 = read
//  cmd_reg_addr  in   5  register address 0-31
//  cmd_wdata     in   8  write data
//  rsp_valid     out  1  one-cycle pulse when a command completes
//  rsp_rdata     out  8  read data; holds its value until the next read completes
//  rsp_err       out  1  NACK received, or write to RO register; valid with rsp_valid
//  busy          out  1  transaction in progress
//  scl_out       out  1  SCL drive; 1 = release
//  sda_out       out  1  SDA drive; 1 = release (open-drain)
//  sda_in        in   1  SDA line sense
// BEHAVIOUR
//  - Reset values: scl_out=1, sda_out=1, cmd_ready=0, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, busy=0.
//  - State is IDLE after reset. cmd_ready=1 only in IDLE; cmd fields are latched at accept.
//  - Bit slot = 4 quarters (q0..q3), each CLK_DIV cycles:
//    - SCL is low in q0 and q3, high in q1 and q2.
//    - SDA changes only at the start of q0.
//    - sda_in is sampled on the last cycle of q1.
//  - START: SDA and SCL released q0-q1, SDA low from q2, SCL low in q3.
//  - Repeated START: same as START, with SDA released first in q0.
//  - STOP: SDA low in q0, SCL high q1-q3, SDA released from q3.
//  - Bytes are sent MSB first. The slave ACK (SDA low) is sampled in the 9th slot.
//  - Write frame: START, {DEV_ADDR,0}, A, {3'b0,reg}, A, wdata, A, STOP = 29 slots.
//  - Read frame: START, {DEV_ADDR,0}, A, {3'b0,reg}, A, RSTART, {DEV_ADDR,1}, A, 8 data bits,
//    master NACK (SDA released), STOP = 39 slots.
//  - FSM: IDLE -> START -> TX_BYTE <-> GET_ACK -> (RSTART -> TX_BYTE) | RX_BYTE -> SEND_NACK -> STOP -> DONE -> IDLE.
//  - rsp_valid asserts in DONE, the cycle after STOP slot q3 ends.
//    - Write latency from accept: 29*4*CLK_DIV + 1 cycles.
//    - Read latency from accept: 39*4*CLK_DIV + 1 cycles.
//  - NACK on any byte: go straight to STOP, then DONE with rsp_err=1. rsp_rdata is unchanged.
//  - Write with cmd_reg_addr >= 24: no bus activity; DONE the cycle after accept, rsp_err=1.
//  - Reads of 24-31 are legal.
//  - cmd_valid while busy is ignored (cmd_ready=0). The next command is accepted at the earliest
//    in the cycle after rsp_valid.
//  - Reset mid-transaction: scl_out and sda_out are released on the next cycle with no STOP issued.
//    The slave resynchronises on the next START.
//  - Bit counter runs 7..0; the 9th slot is the ACK. The quarter counter wraps at CLK_DIV-1.
// STRUCTURE
//  - Package cyborg65r2_i2c_pkg:
//    - state enum
//    - REG_RW_LAST=5'd23, REG_RO_FIRST=5'd24
//    - slot/quarter encodings
//    - DEFAULT_DEV_ADDR
//  - Sub-module cyborg65r2_i2c_qtick: quarter-period tick and q0-q3 phase counter.
//  - Top: FSM, shift register, bit counter.
// TESTING (CLK_DIV=4, DEV_ADDR=7'h52, bench slave model on scl_out/sda_out)
//  1. Write reg 7 = 8'hA5 -> bus bytes A4,07,A5 all ACKed, STOP;
//     rsp_valid at accept+465, rsp_err=0; model reg7=A5.
//  2. Read reg 25, model returns 8'h3C -> bytes A4,19, RSTART, A5, data 3C, master NACK, STOP;
//     rsp_rdata=3C, rsp_err=0, at accept+625.
//  3. Model NACKs device address -> STOP right after slot 9; rsp_err=1;
//     no further SCL pulses; rsp_rdata unchanged.
//  4. Write reg 26 -> rsp_valid=1, rsp_err=1 one cycle after accept;
//     scl_out and sda_out stay 1 throughout.
//  5. reset asserted during bit 3 of the reg byte -> next cycle scl_out=1, sda_out=1, busy=0;
//     a fresh write of reg 0 = 8'h11 then completes correctly.
//  6. cmd_valid held for two commands -> cmd_ready=0 while busy;
//     second command accepted in the cycle after the first rsp_valid.

Source files
------------

// File: rtl/cyborg65r2_i2c_pkg.sv
// Shared types and constants for the CYBORG65R2 I2C master.
// Holds the FSM state enum, register-map limits, quarter/byte encodings.
package cyborg65r2_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_GET_ACK,
        ST_RSTART,
        ST_RX_BYTE,
        ST_SEND_NACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [4:0] REG_RW_LAST  = 5'd23;
    localparam logic [4:0] REG_RO_FIRST = REG_RW_LAST + 5'd1;

    // Quarter encodings inside one bit slot
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Which byte of the frame is on the wire
    localparam logic [1:0] BY_ADDR_W = 2'd0;
    localparam logic [1:0] BY_REG    = 2'd1;
    localparam logic [1:0] BY_DATA   = 2'd2;
    localparam logic [1:0] BY_ADDR_R = 2'd3;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h52;

    function automatic logic is_ro(input logic [4:0] a);
        return (a >= REG_RO_FIRST);
    endfunction

endpackage

// File: rtl/cyborg65r2_i2c_master_qtick.sv
// Quarter-period timer: counts CLK_DIV cycles per quarter, 4 quarters/slot.
// Ports: i_clk, i_reset, i_run (hold at q0 when low), o_q, o_q_last, o_slot_end.
module cyborg65r2_i2c_qtick
    import cyborg65r2_i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    output logic [1:0] o_q,
    output logic       o_q_last,
    output logic       o_slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;

    assign o_q        = r_q;
    assign o_q_last   = (r_cnt == CW'(CLK_DIV - 1));
    assign o_slot_end = o_q_last && (r_q == Q3);

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (o_q_last) begin
            r_cnt <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cyborg65r2_i2c_master.sv
// I2C bus master for single-register write/read of the CYBORG65R2 slave.
// Ports: clk/reset, cmd_* request, rsp_* response, busy, scl_out/sda_out/sda_in.
module cyborg65r2_i2c_master
    import cyborg65r2_i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 25,
    parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [4:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_out,
    output logic       sda_out,
    input  logic       sda_in
);

    state_t     r_state;
    state_t     w_next;
    logic       r_ready;
    logic       r_rw;
    logic [4:0] r_reg;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic [1:0] r_byte;
    logic       r_nack;
    logic       r_err;
    logic [7:0] r_rdata;

    logic       w_run;
    logic [1:0] w_q;
    logic       w_q_last;
    logic       w_slot_end;
    logic       w_sample;
    logic       w_scl_hi;
    logic       w_accept;
    logic       w_scl;
    logic       w_sda;

    assign w_run    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_sample = w_q_last && (w_q == Q1);
    assign w_scl_hi = (w_q == Q1) || (w_q == Q2);
    assign w_accept = (r_state == ST_IDLE) && cmd_valid && r_ready;

    cyborg65r2_i2c_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_run      (w_run),
        .o_q        (w_q),
        .o_q_last   (w_q_last),
        .o_slot_end (w_slot_end)
    );

    always_comb begin
        w_next = r_state;
        w_scl  = 1'b1;
        w_sda  = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (!cmd_rw && is_ro(cmd_reg_addr)) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                w_scl = (w_q != Q3);
                w_sda = (w_q == Q0) || (w_q == Q1);
                if (w_slot_end) w_next = ST_TX_BYTE;
            end
            ST_RSTART: begin
                w_scl = w_scl_hi;
                w_sda = (w_q == Q0) || (w_q == Q1);
                if (w_slot_end) w_next = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                w_scl = w_scl_hi;
                w_sda = r_shift[7];
                if (w_slot_end && r_bit == 3'd0) w_next = ST_GET_ACK;
            end
            ST_GET_ACK: begin
                w_scl = w_scl_hi;
                if (w_slot_end) begin
                    if (r_nack) begin
                        w_next = ST_STOP;
                    end else begin
                        unique case (r_byte)
                            BY_ADDR_W: w_next = ST_TX_BYTE;
                            BY_REG:    w_next = r_rw ? ST_RSTART : ST_TX_BYTE;
                            BY_DATA:   w_next = ST_STOP;
                            BY_ADDR_R: w_next = ST_RX_BYTE;
                            default:   w_next = ST_STOP;
                        endcase
                    end
                end
            end
            ST_RX_BYTE: begin
                w_scl = w_scl_hi;
                if (w_slot_end && r_bit == 3'd0) w_next = ST_SEND_NACK;
            end
            ST_SEND_NACK: begin
                w_scl = w_scl_hi;
                if (w_slot_end) w_next = ST_STOP;
            end
            ST_STOP: begin
                w_scl = (w_q != Q0);
                w_sda = (w_q == Q3);
                if (w_slot_end) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rw    <= 1'b0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_bit   <= 3'd7;
            r_byte  <= BY_ADDR_W;
            r_nack  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            // Ready is registered so it stays low during reset
            r_ready <= (w_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rw    <= cmd_rw;
                        r_reg   <= cmd_reg_addr;
                        r_wdata <= cmd_wdata;
                        r_err   <= !cmd_rw && is_ro(cmd_reg_addr);
                        r_nack  <= 1'b0;
                        r_byte  <= BY_ADDR_W;
                        r_shift <= {DEV_ADDR, 1'b0};
                        r_bit   <= 3'd7;
                    end
                end
                ST_TX_BYTE: begin
                    if (w_slot_end) begin
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_bit   <= r_bit - 3'd1;
                    end
                end
                ST_GET_ACK: begin
                    if (w_sample) r_nack <= sda_in;
                    if (w_slot_end) begin
                        r_bit <= 3'd7;
                        if (r_nack) begin
                            r_err <= 1'b1;
                        end else if (r_byte == BY_ADDR_W) begin
                            r_byte  <= BY_REG;
                            r_shift <= {3'b000, r_reg};
                        end else if (r_byte == BY_REG) begin
                            // Read reloads the address byte now; it goes out after RSTART
                            r_byte  <= r_rw ? BY_ADDR_R : BY_DATA;
                            r_shift <= r_rw ? {DEV_ADDR, 1'b1} : r_wdata;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (w_sample) r_shift <= {r_shift[6:0], sda_in};
                    if (w_slot_end) r_bit <= r_bit - 3'd1;
                end
                ST_STOP: begin
                    if (w_slot_end && r_rw && !r_err) r_rdata <= r_shift;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_err   = (r_state == ST_DONE) && r_err;
    assign rsp_rdata = r_rdata;
    assign scl_out   = w_scl;
    assign sda_out   = w_sda;

endmodule

// File: tb/tb_cyborg65r2_i2c_master.sv
// Self-checking bench for cyborg65r2_i2c_master with a behavioural slave.
// Table-driven command rows plus hand-written reset/back-to-back sequences.
module tb_cyborg65r2_i2c_master;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [4:0] cmd_reg_addr = 5'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       scl_out;
    logic       sda_out;
    logic       sda_in;

    logic       slv_sda;
    logic       nack_addr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign sda_in = sda_out & slv_sda;

    cyborg65r2_i2c_master #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h52)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .scl_out      (scl_out),
        .sda_out      (sda_out),
        .sda_in       (sda_in)
    );

    // Slave model, sampled on the falling clock edge
    logic [7:0] regs [32];
    logic [7:0] blog [64];
    int         n_log, n_rise, n_start, n_stop;
    int         mode, nb, bi;
    logic       ack_ph, go_read, went_nack, mack;
    logic       p_scl, p_sda;
    logic [7:0] sh, tsh;
    logic [4:0] sreg;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 25) ? 8'h3C : 8'h00;
            n_log <= 0; n_rise <= 0; n_start <= 0; n_stop <= 0;
            mode <= 0; nb <= 0; bi <= 0;
            ack_ph <= 1'b0; go_read <= 1'b0; went_nack <= 1'b0; mack <= 1'b0;
            p_scl <= 1'b1; p_sda <= 1'b1; slv_sda <= 1'b1;
            sh <= 8'h00; tsh <= 8'h00; sreg <= 5'd0;
        end else begin
            if (p_scl && scl_out && p_sda && !sda_in) begin
                n_start <= n_start + 1;
                mode <= 1; nb <= 0; bi <= 0; ack_ph <= 1'b0; slv_sda <= 1'b1;
            end else if (p_scl && scl_out && !p_sda && sda_in) begin
                n_stop <= n_stop + 1;
                mode <= 0; ack_ph <= 1'b0; slv_sda <= 1'b1;
            end else if (!p_scl && scl_out) begin
                n_rise <= n_rise + 1;
                if (mode == 1 && !ack_ph && nb < 8) begin
                    sh <= {sh[6:0], sda_in};
                    nb <= nb + 1;
                end else if (mode == 2) begin
                    if (nb == 8) mack <= sda_in;
                    nb <= nb + 1;
                end
            end else if (p_scl && !scl_out) begin
                if (mode == 1 && !ack_ph && nb == 8) begin
                    ack_ph <= 1'b1;
                    blog[n_log % 64] <= sh;
                    n_log <= n_log + 1;
                    bi <= bi + 1;
                    if (bi == 0) begin
                        if (sh[7:1] == 7'h52 && !nack_addr) begin
                            slv_sda <= 1'b0; went_nack <= 1'b0; go_read <= sh[0];
                        end else begin
                            slv_sda <= 1'b1; went_nack <= 1'b1; go_read <= 1'b0;
                        end
                    end else if (bi == 1) begin
                        sreg <= sh[4:0];
                        slv_sda <= 1'b0; went_nack <= 1'b0; go_read <= 1'b0;
                    end else begin
                        regs[sreg] <= sh;
                        slv_sda <= 1'b0; went_nack <= 1'b0; go_read <= 1'b0;
                    end
                end else if (mode == 1 && ack_ph) begin
                    ack_ph <= 1'b0;
                    nb <= 0;
                    slv_sda <= 1'b1;
                    if (went_nack) begin
                        mode <= 0;
                    end else if (go_read) begin
                        mode <= 2;
                        tsh <= regs[sreg];
                        slv_sda <= regs[sreg][7];
                    end
                end else if (mode == 2) begin
                    slv_sda <= (nb < 8) ? tsh[7 - nb] : 1'b1;
                end
            end
            p_scl <= scl_out;
            p_sda <= sda_in;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic rw, input logic [4:0] ra,
                           input logic [7:0] wd, output int lat,
                           output logic err, output logic [7:0] rd,
                           output logic low);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_reg_addr = ra; cmd_wdata = wd;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", int'(cmd_ready), 1);
        lat = 0; low = 1'b0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_valid = 1'b0;
            if (!scl_out || !sda_out) low = 1'b1;
            if (rsp_valid) break;
        end
        cmd_valid = 1'b0;
        err = rsp_err;
        rd = rsp_rdata;
    endtask

    typedef struct {
        logic       rw;
        logic [4:0] ra;
        logic [7:0] wd;
        logic       nack;
        int         lat;
        logic       err;
        logic [7:0] rdata;
        int         rises;
        int         starts;
        int         stops;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       bus_low;
    } vec_t;

    vec_t vec [4];

    initial begin
        int         lat;
        logic       err, low;
        logic [7:0] rd, eb;
        int         r0, s0, p0, l0, rdy_bad, g;

        vec[0] = '{1'b0, 5'd7,  8'hA5, 1'b0, 465, 1'b0, 8'h00, 28, 1, 1, 3,
                   8'hA4, 8'h07, 8'hA5, 1'b1};
        vec[1] = '{1'b1, 5'd25, 8'h00, 1'b0, 625, 1'b0, 8'h3C, 38, 2, 1, 3,
                   8'hA4, 8'h19, 8'hA5, 1'b1};
        vec[2] = '{1'b0, 5'd5,  8'h77, 1'b1, 177, 1'b1, 8'h3C, 10, 1, 1, 1,
                   8'hA4, 8'h00, 8'h00, 1'b1};
        vec[3] = '{1'b0, 5'd26, 8'h99, 1'b0, 1,   1'b1, 8'h3C, 0,  0, 0, 0,
                   8'h00, 8'h00, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_scl", int'(scl_out), 1);
        chk("rst_sda", int'(sda_out), 1);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_err", int'(rsp_err), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 4; i++) begin
            nack_addr = vec[i].nack;
            r0 = n_rise; s0 = n_start; p0 = n_stop; l0 = n_log;
            run_cmd(vec[i].rw, vec[i].ra, vec[i].wd, lat, err, rd, low);
            chk($sformatf("v%0d_latency", i), lat, vec[i].lat);
            chk($sformatf("v%0d_err", i), int'(err), int'(vec[i].err));
            chk($sformatf("v%0d_rdata", i), int'(rd), int'(vec[i].rdata));
            chk($sformatf("v%0d_scl_rises", i), n_rise - r0, vec[i].rises);
            chk($sformatf("v%0d_starts", i), n_start - s0, vec[i].starts);
            chk($sformatf("v%0d_stops", i), n_stop - p0, vec[i].stops);
            chk($sformatf("v%0d_nbytes", i), n_log - l0, vec[i].nbytes);
            chk($sformatf("v%0d_bus_low", i), int'(low), int'(vec[i].bus_low));
            for (int k = 0; k < vec[i].nbytes; k++) begin
                eb = (k == 0) ? vec[i].b0 : (k == 1) ? vec[i].b1 : vec[i].b2;
                chk($sformatf("v%0d_byte%0d", i, k), int'(blog[(l0 + k) % 64]), int'(eb));
            end
            if (vec[i].rw) chk($sformatf("v%0d_master_nack", i), int'(mack), 1);
            if (!vec[i].rw && !vec[i].err)
                chk($sformatf("v%0d_slave_reg", i), int'(regs[vec[i].ra]), int'(vec[i].wd));
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_idle_scl", i), int'(scl_out), 1);
        end
        nack_addr = 1'b0;

        // Reset in the middle of bit 3 of the register byte
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_reg_addr = 5'd9; cmd_wdata = 8'h42;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        chk("mid_accept", int'(cmd_ready), 1);
        for (int n = 1; n <= 231; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid = 1'b0;
            if (n == 230) begin
                chk("mid_busy_before", int'(busy), 1);
                reset = 1'b1;
            end
            if (n == 231) begin
                chk("mid_rst_scl", int'(scl_out), 1);
                chk("mid_rst_sda", int'(sda_out), 1);
                chk("mid_rst_busy", int'(busy), 0);
                reset = 1'b0;
            end
        end
        run_cmd(1'b0, 5'd0, 8'h11, lat, err, rd, low);
        chk("post_rst_latency", lat, 465);
        chk("post_rst_err", int'(err), 0);
        chk("post_rst_reg0", int'(regs[0]), 8'h11);

        // cmd_valid held across two commands
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_reg_addr = 5'd3; cmd_wdata = 8'h5A;
        g = 0;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        chk("b2b_accept1", int'(cmd_ready), 1);
        lat = 0; rdy_bad = 0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin cmd_reg_addr = 5'd4; cmd_wdata = 8'h66; end
            if (cmd_ready) rdy_bad++;
            if (rsp_valid) break;
        end
        chk("b2b_lat1", lat, 465);
        chk("b2b_ready_while_busy", rdy_bad, 0);
        @(negedge clk);
        chk("b2b_accept2_next_cycle", int'(cmd_ready), 1);
        lat = 0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) cmd_valid = 1'b0;
            if (rsp_valid) break;
        end
        chk("b2b_lat2", lat, 465);
        chk("b2b_reg3", int'(regs[3]), 8'h5A);
        chk("b2b_reg4", int'(regs[4]), 8'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
